count_sampler: RTL

Downstream consumer of the free-running 8-bit counter stage. Decimates the incoming count by a fixed period, buffers samples in a small FIFO drained through a valid/ready port, and counts samples lost to overflow. It also checks that the input advances by exactly +1 every cycle, and flags any discontinuity with a sticky error.

---
 rtl/count_sampler.sv | 130 +++++++++++++
 1 files changed

// File: rtl/count_sampler.sv
// count_sampler: decimates a free-running count into a valid/ready FIFO, counts overflow drops,
// and flags any break in the +1-per-cycle input sequence with a sticky error.  Rev 1.0
`default_nettype none

module count_sampler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [7:0]                 drop_count,
  output logic                       seq_err
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } chk_state_t;

  logic [DCW-1:0]   div_cnt_q, div_cnt_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [7:0]       drop_q, drop_d;
  chk_state_t       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] prev_inc;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic strobe, full, pop, push, drop;

  always_comb begin
    strobe    = en && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    if (en) begin
      div_cnt_d = strobe ? '0 : div_cnt_q + 1'b1;
    end

    full = (level_q == FULL_LVL);
    pop  = (level_q != '0) && out_ready;
    // A pop frees the slot the same cycle, so a full FIFO still accepts the strobe.
    push = strobe && (!full || pop);
    drop = strobe && full && !pop;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    drop_d = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    prev_inc = prev_q + 1'b1;
    case (state_q)
      ARM: begin
        prev_d  = data_in;
        state_d = TRACK;
      end
      TRACK: begin
        if (data_in == prev_inc) begin
          prev_d = data_in;
        end else begin
          state_d = ERROR;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= '0;
      state_q   <= ARM;
      prev_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
      prev_q    <= prev_d;
    end
  end

  // Storage needs no reset: out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign out_valid  = (level_q != '0);
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level      = level_q;
  assign drop_count = drop_q;
  assign seq_err    = (state_q == ERROR);

endmodule

`default_nettype wire
